// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the CPU port, the DMA port and the memory-macro port that the
//   byte-memory arbiter sits between.
//   Parameters: AW address width, DW data width.
//   Modports:
//     slave  - the arbiter's view: request inputs and mem_rdata in;
//              acks, read data, mem_* strobes and owner out.
//     master - the surrounding system's view (CPU, DMA and memory macro).
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide synchronous memory between the CPU and a DMA/loader
//   port. Every access is a single byte moved by a four-state sequencer
//   IDLE -> ACC -> RESP -> DONE. A CPU lock keeps ownership across the bytes
//   of an instruction fetch so DMA cannot interleave.
//   Ports:
//     clk    - clock
//     reset  - synchronous, active-high
//     bus    - mem_arbiter_if.slave: CPU port, DMA port, memory port, owner
//   Build option:
//     ARB_ROUND_ROBIN_EN - when defined, contention (with no lock held) goes
//                          to the port that was not served last; otherwise
//                          the CPU always wins contention.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, RESP, DONE} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          lock_q, lock_d;
  logic          last_owner_q, last_owner_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          we_q, we_d;
  logic          contend_dma;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Winner when both ports request and no lock is held.
`ifdef ARB_ROUND_ROBIN_EN
  assign contend_dma = ~last_owner_q;
`else
  assign contend_dma = 1'b0;
`endif

  // Owner's port fields, steered onto the memory bus during ACC.
  assign sel_we    = owner_q ? bus.dma_we    : bus.cpu_we;
  assign sel_addr  = owner_q ? bus.dma_addr  : bus.cpu_addr;
  assign sel_wdata = owner_q ? bus.dma_wdata : bus.cpu_wdata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_d       = lock_q;
    last_owner_d = last_owner_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    we_d         = we_q;

    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_ack   = 1'b0;
    bus.dma_ack   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.cpu_lock) lock_d = 1'b0;
        // A held lock reserves the memory for the CPU even if DMA is asking.
        if (lock_q) begin
          if (bus.cpu_req) begin
            owner_d = 1'b0;
            state_d = ACC;
          end
        end else if (bus.cpu_req && bus.dma_req) begin
          owner_d = contend_dma;
          state_d = ACC;
        end else if (bus.cpu_req) begin
          owner_d = 1'b0;
          state_d = ACC;
        end else if (bus.dma_req) begin
          owner_d = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        // Reset kills the strobe in the same cycle so no write lands.
        if (!reset) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = sel_we;
          bus.mem_addr  = sel_addr;
          bus.mem_wdata = sel_wdata;
        end
        // Remember the direction; the requester may change its inputs later.
        we_d    = sel_we;
        state_d = RESP;
      end
      RESP: begin
        if (!we_q) begin
          if (owner_q) dma_rdata_d = bus.mem_rdata;
          else         cpu_rdata_d = bus.mem_rdata;
        end
        state_d = DONE;
      end
      DONE: begin
        if (!reset) begin
          bus.cpu_ack = ~owner_q;
          bus.dma_ack = owner_q;
        end
        last_owner_d = owner_q;
        if (!owner_q && bus.cpu_lock) lock_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      lock_q       <= 1'b0;
      last_owner_q <= 1'b1;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      last_owner_q <= last_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q <= we_d;
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a byte memory model behind the
//   memory port. Stimulus is driven and outputs sampled 1 time unit after
//   each rising clock edge.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [256];
  int         cyc = 0;
  int         cpu_acks = 0;
  int         dma_acks = 0;
  logic       glog_owner [$];
  int         glog_cyc   [$];

  // Memory macro model: one-cycle read latency, write on the strobe edge.
  // Also logs every granted access (owner seen while mem_en is high).
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
      glog_owner.push_back(bus.owner);
      glog_cyc.push_back(cyc);
    end
    if (bus.cpu_ack) cpu_acks <= cpu_acks + 1;
    if (bus.dma_ack) dma_acks <= dma_acks + 1;
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks ACC, RESP, DONE of an access whose IDLE sample edge is the next
  // edge; the ack must appear only in the third cycle after that edge.
  task automatic expect_ack(input string tag, input bit is_dma);
    tick();
    chk({tag, "_acc_en"},  {31'd0, bus.mem_en}, 32'd1);
    chk({tag, "_acc_ack"}, {31'd0, is_dma ? bus.dma_ack : bus.cpu_ack}, 32'd0);
    tick();
    chk({tag, "_resp_ack"}, {31'd0, is_dma ? bus.dma_ack : bus.cpu_ack}, 32'd0);
    tick();
    chk({tag, "_done_ack"},   {31'd0, is_dma ? bus.dma_ack : bus.cpu_ack}, 32'd1);
    chk({tag, "_done_other"}, {31'd0, is_dma ? bus.cpu_ack : bus.dma_ack}, 32'd0);
  endtask

  int   base;
  logic exp_own;

  initial begin
    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_lock  = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 8'h00;
    bus.dma_wdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h00] <= 8'hA0;
    mem[8'h01] <= 8'hA1;
    mem[8'h02] <= 8'hA2;
    mem[8'h03] <= 8'hA3;
    mem[8'h10] <= 8'h77;
    mem[8'h20] <= 8'h5A;
    mem[8'h30] <= 8'h11;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cpu_ack",   {31'd0, bus.cpu_ack}, 32'd0);
    chk("rst_dma_ack",   {31'd0, bus.dma_ack}, 32'd0);
    chk("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'h00);
    chk("rst_dma_rdata", {24'd0, bus.dma_rdata}, 32'h00);
    chk("rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr",  {24'd0, bus.mem_addr}, 32'h00);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'h00);
    chk("rst_owner",     {31'd0, bus.owner}, 32'd0);

    // Reset during ACC of a DMA write
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 8'h10;
    bus.dma_wdata = 8'hAA;
    tick();
    chk("abort_acc_en",    {31'd0, bus.mem_en}, 32'd1);
    chk("abort_acc_we",    {31'd0, bus.mem_we}, 32'd1);
    chk("abort_acc_owner", {31'd0, bus.owner}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("abort_rst_en", {31'd0, bus.mem_en}, 32'd0);
    bus.dma_req = 1'b0;
    bus.dma_we  = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("abort_mem10", {24'd0, mem[8'h10]}, 32'h77);
    chk("abort_noack", dma_acks, 32'd0);
    chk("abort_owner", {31'd0, bus.owner}, 32'd0);

    // CPU write then read
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 8'h05;
    bus.cpu_wdata = 8'h3C;
    expect_ack("cpu_wr", 1'b0);
    bus.cpu_req = 1'b0;
    tick();
    chk("cpu_wr_mem", {24'd0, mem[8'h05]}, 32'h3C);
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    expect_ack("cpu_rd", 1'b0);
    chk("cpu_rd_data", {24'd0, bus.cpu_rdata}, 32'h3C);
    bus.cpu_req = 1'b0;
    tick();

    // Request dropped after grant
    glog_owner.delete();
    glog_cyc.delete();
    base         = dma_acks;
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b0;
    bus.dma_addr = 8'h20;
    tick();
    chk("drop_owner", {31'd0, bus.owner}, 32'd1);
    chk("drop_addr",  {24'd0, bus.mem_addr}, 32'h20);
    bus.dma_req = 1'b0;
    tick();
    chk("drop_resp_ack", {31'd0, bus.dma_ack}, 32'd0);
    tick();
    chk("drop_done_ack", {31'd0, bus.dma_ack}, 32'd1);
    chk("drop_rdata",    {24'd0, bus.dma_rdata}, 32'h5A);
    repeat (4) tick();
    chk("drop_one_grant", glog_owner.size(), 32'd1);
    chk("drop_one_ack",   dma_acks - base, 32'd1);

    // DMA write keeps the previous read data
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b0;
    bus.dma_addr = 8'h30;
    expect_ack("dma_rd", 1'b1);
    chk("dma_rd_data", {24'd0, bus.dma_rdata}, 32'h11);
    bus.dma_req = 1'b0;
    tick();
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 8'h31;
    bus.dma_wdata = 8'h22;
    expect_ack("dma_wr", 1'b1);
    chk("dma_wr_keep", {24'd0, bus.dma_rdata}, 32'h11);
    bus.dma_req = 1'b0;
    bus.dma_we  = 1'b0;
    tick();
    chk("dma_wr_mem", {24'd0, mem[8'h31]}, 32'h22);

    // Contention, both requests raised together and held
    glog_owner.delete();
    glog_cyc.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 8'h05;
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b0;
    bus.dma_addr = 8'h20;
    repeat (16) tick();
    bus.cpu_req = 1'b0;
    repeat (3) tick();
    bus.dma_req = 1'b0;
    tick();
    chk("cont_grants", glog_owner.size(), 32'd5);
    if (glog_owner.size() == 5) begin
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_own = (k % 2 == 1);
`else
        exp_own = 1'b0;
`endif
        chk($sformatf("cont_owner%0d", k), {31'd0, glog_owner[k]}, {31'd0, exp_own});
        chk($sformatf("cont_gap%0d", k), glog_cyc[k+1] - glog_cyc[k], 32'd4);
      end
      chk("cont_dma_after", {31'd0, glog_owner[4]}, 32'd1);
    end

    // Locked 4-byte CPU fetch with DMA waiting
    glog_owner.delete();
    glog_cyc.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_lock = 1'b1;
    bus.cpu_addr = 8'h00;
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b0;
    bus.dma_addr = 8'h20;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk($sformatf("lock_acc_owner%0d", b), {31'd0, bus.owner}, 32'd0);
      tick();
      chk($sformatf("lock_resp_owner%0d", b), {31'd0, bus.owner}, 32'd0);
      tick();
      chk($sformatf("lock_ack%0d", b), {31'd0, bus.cpu_ack}, 32'd1);
      chk($sformatf("lock_data%0d", b), {24'd0, bus.cpu_rdata}, {24'd0, 8'(8'hA0 + b)});
      tick();
      if (b < 3) begin
        bus.cpu_addr = 8'(b + 1);
        bus.cpu_lock = (b + 1 < 3);
      end else begin
        bus.cpu_req  = 1'b0;
        bus.cpu_lock = 1'b0;
      end
    end
    tick();
    chk("lock_dma_owner", {31'd0, bus.owner}, 32'd1);
    chk("lock_dma_addr",  {24'd0, bus.mem_addr}, 32'h20);
    tick();
    tick();
    chk("lock_dma_ack",   {31'd0, bus.dma_ack}, 32'd1);
    chk("lock_dma_rdata", {24'd0, bus.dma_rdata}, 32'h5A);
    bus.dma_req = 1'b0;
    tick();
    chk("lock_grants", glog_owner.size(), 32'd5);
    if (glog_owner.size() == 5) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("lock_log%0d", k), {31'd0, glog_owner[k]}, 32'd0);
      chk("lock_log4", {31'd0, glog_owner[4]}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single byte-wide synchronous memory between the multicycle CPU and a DMA/loader port. Each access is a single-byte read or write through a four-state sequencer. A CPU lock keeps ownership across the four byte fetches of one instruction, so DMA traffic cannot interleave within a fetch. The block sits between the CPU datapath memory port and the memory macro.

## Interface
- AW, 8, address width
- DW, 8, data width (byte)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; hold until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_lock  in  1  keep CPU ownership for the next access (fetch burst)
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  registered CPU read data
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: DMA port, same widths and semantics as the CPU port; no lock input
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after the mem_en edge
- owner  out  1  current/last grant (0 = CPU, 1 = DMA)

## Operation
- FSM states: IDLE → ACC → RESP → DONE → IDLE. No other transitions except reset.
- IDLE:
  - Sample the requests. If none is high, stay in IDLE.
  - Otherwise register the grant into `owner` and go to ACC.
- Grant rules in IDLE, in priority order:
  1. If lock_r=1: grant the CPU only when cpu_req=1. DMA waits.
  2. If exactly one port requests: grant that port.
  3. If both ports request: resolve per Configuration.
- ACC:
  - mem_en=1.
  - mem_we, mem_addr and mem_wdata are driven combinationally from the owner's port inputs.
  - Outside ACC, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
- RESP:
  - On a read, the owner's rdata register loads mem_rdata at the end of this cycle.
  - On a write, rdata holds its previous value.
- DONE:
  - The owner's ack is 1; the other port's ack is 0.
  - Requests are ignored in DONE. A request still high is re-sampled in the following IDLE as a new access.
- lock_r:
  - Set at the end of DONE when owner=0 and cpu_lock=1.
  - Cleared at the end of IDLE whenever cpu_lock=0.
- last_owner: updated to `owner` at the end of DONE.
- A requester dropping req after the grant does not abort the access. It completes, and ack still pulses.
- Reset values: state IDLE, owner 0, lock_r 0, last_owner 1, both rdata 0, both acks 0. All mem_* outputs are 0.
- Reset asserted in any state:
  - mem_en and mem_we are forced to 0 combinationally in that same cycle, so no write is committed.
  - The FSM is in IDLE on the next cycle, and no ack is issued for the aborted access.

## Timing
- The req sample edge ends IDLE (cycle N). ACC is N+1, RESP is N+2, ack is high in N+3 (DONE).
- Read data is valid in the rdata register from N+3 on and is held until the next read by the same port.
- Maximum throughput is one access per 4 cycles. A back-to-back request is granted in the IDLE cycle at N+4.
- Locked CPU fetch of 4 bytes: 16 cycles, with no DMA access interleaved.
- Lock starvation bound: DMA is delayed indefinitely while the CPU holds cpu_lock with cpu_req high. This is the CPU's responsibility: the lock is released after the 4th fetch byte.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On contention with lock_r=0, grant the port that is not last_owner.
  - Because last_owner resets to 1, the CPU wins the first contention.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the CPU always wins contention.
  - last_owner is still maintained but does not affect grants.

## Test plan
- **Reset state**: after reset, check all outputs against the reset values. Assert reset during ACC of a DMA write (addr 0x10, data 0xAA): mem_we=0 that cycle, mem[0x10] unchanged, no dma_ack.
- **CPU write then read**: CPU write 0x3C to 0x05, ack at N+3. Then CPU read of 0x05: cpu_rdata=0x3C with cpu_ack exactly 3 cycles after the IDLE sample edge.
- **Contention**: cpu_req and dma_req raised in the same cycle, held.
  - With ARB_ROUND_ROBIN_EN: grants alternate CPU, DMA, CPU, DMA, each 4 cycles apart.
  - Without it: CPU served continuously, and DMA is granted only after cpu_req drops.
- **Locked fetch**: CPU reads 0x00–0x03 with cpu_lock=1 on bytes 0–2 and 0 on byte 3, while dma_req is held high. The DMA grant appears only after the 4th CPU ack, and owner never goes to 1 before then.
- **Request drop**: DMA read of 0x20 (mem=0x5A) with dma_req deasserted in ACC. The access completes, dma_ack pulses at N+3 and dma_rdata=0x5A. No second access occurs.
- **Write preserves rdata**: DMA read yields 0x11, then a DMA write of 0x22 to another address. dma_rdata stays 0x11 after the write ack.
